// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified memory-port arbiter.
// Contents: arbiter FSM state type, default byte-enable width and default bus timeout,
// and a small helper that tells whether a state belongs to an instruction fetch.
package mem_arbiter_pkg;

  localparam int unsigned MEM_BE_WIDTH = 4;
  localparam int unsigned BUS_TIMEOUT  = 255;

  typedef enum logic [2:0] {
    StIdle,
    StReqD,
    StWaitD,
    StReqI,
    StWaitI
  } arb_state_t;

  function automatic logic is_fetch_state(arb_state_t state);
    return (state == StReqI) || (state == StWaitI);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the pipeline-side (IF and MEM stages) and bus-side signals of the arbiter.
// Modports:
//   slave  - arbiter view: pipeline requests and bus responses in; results, stall, bus out
//   master - environment view: the pipeline plus the memory bus (directions mirrored)
interface mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) ();

  localparam int unsigned BeWidth = DATA_WIDTH / 8;

  // Instruction fetch side
  logic                  ifReq;
  logic [ADDR_WIDTH-1:0] ifAddr;
  logic                  ifKill;
  logic [DATA_WIDTH-1:0] ifRdata;
  logic                  ifDone;
  // Data access side
  logic                  memReq;
  logic                  memWe;
  logic [BeWidth-1:0]    memBe;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic [DATA_WIDTH-1:0] memWdata;
  logic [DATA_WIDTH-1:0] memRdata;
  logic                  memDone;
  // Memory bus
  logic                  busReq;
  logic                  busWe;
  logic [BeWidth-1:0]    busBe;
  logic [ADDR_WIDTH-1:0] busAddr;
  logic [DATA_WIDTH-1:0] busWdata;
  logic                  busGnt;
  logic                  busRvalid;
  logic [DATA_WIDTH-1:0] busRdata;
  // Pipeline control / status
  logic                  stall_n;
  logic                  busErr;

  modport slave (
    input  ifReq, ifAddr, ifKill, memReq, memWe, memBe, memAddr, memWdata,
    input  busGnt, busRvalid, busRdata,
    output ifRdata, ifDone, memRdata, memDone,
    output busReq, busWe, busBe, busAddr, busWdata, stall_n, busErr
  );

  modport master (
    output ifReq, ifAddr, ifKill, memReq, memWe, memBe, memAddr, memWdata,
    output busGnt, busRvalid, busRdata,
    input  ifRdata, ifDone, memRdata, memDone,
    input  busReq, busWe, busBe, busAddr, busWdata, stall_n, busErr
  );

endinterface

// File: rtl/mem_arbiter_bus_timer.sv
// Watchdog counter for one outstanding bus transaction.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   i_clear     - force the count back to zero (arbiter idle)
//   i_run       - a transaction is outstanding; count one per cycle
//   o_expired   - high during the TIMEOUT_CYCLES-th outstanding cycle
module mem_arbiter_bus_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expired
);

  localparam int unsigned CntWidth = $clog2(TIMEOUT_CYCLES + 1);
  // Count starts at 0 in the first outstanding cycle, so the last allowed cycle sees N-1.
  localparam logic [CntWidth-1:0] LastCount = CntWidth'(TIMEOUT_CYCLES - 1);

  logic [CntWidth-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_run && !o_expired) begin
      r_count <= r_count + CntWidth'(1);
    end
  end

  assign o_expired = i_run && (r_count == LastCount);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one memory bus between instruction fetch and data access.
// Data accesses win; one transaction is outstanding at a time; results are held until the
// pipeline advances (stall_n high), and a watchdog aborts transactions that never finish.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   io_arb     - mem_arbiter_if.slave: IF/MEM requests and results, registered bus outputs,
//                bus grant/response, combinational stall_n, sticky busErr
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = BUS_TIMEOUT
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave io_arb
);

  localparam int unsigned BeWidth = DATA_WIDTH / 8;

  arb_state_t            r_state,       w_state_next;
  logic                  r_bus_req,     w_bus_req_next;
  logic                  r_bus_we,      w_bus_we_next;
  logic [BeWidth-1:0]    r_bus_be,      w_bus_be_next;
  logic [ADDR_WIDTH-1:0] r_bus_addr,    w_bus_addr_next;
  logic [DATA_WIDTH-1:0] r_bus_wdata,   w_bus_wdata_next;
  logic [DATA_WIDTH-1:0] r_if_rdata,    w_if_rdata_next;
  logic                  r_if_done,     w_if_done_next;
  logic [DATA_WIDTH-1:0] r_mem_rdata,   w_mem_rdata_next;
  logic                  r_mem_done,    w_mem_done_next;
  logic                  r_if_drop,     w_if_drop_next;
  logic                  r_bus_err,     w_bus_err_next;
  logic                  w_stall_n;
  logic                  w_timer_run;
  logic                  w_timer_expired;
  logic                  w_rsp_now;

  assign w_stall_n   = !((io_arb.memReq && !r_mem_done) || (io_arb.ifReq && !r_if_done));
  assign w_timer_run = (r_state != StIdle);
  assign w_rsp_now   = io_arb.busRvalid && ((r_state == StWaitD) || (r_state == StWaitI));

  mem_arbiter_bus_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_bus_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (!w_timer_run),
    .i_run    (w_timer_run),
    .o_expired(w_timer_expired)
  );

  always_comb begin
    w_state_next     = r_state;
    w_bus_req_next   = r_bus_req;
    w_bus_we_next    = r_bus_we;
    w_bus_be_next    = r_bus_be;
    w_bus_addr_next  = r_bus_addr;
    w_bus_wdata_next = r_bus_wdata;
    w_if_rdata_next  = r_if_rdata;
    w_if_done_next   = r_if_done;
    w_mem_rdata_next = r_mem_rdata;
    w_mem_done_next  = r_mem_done;
    w_if_drop_next   = r_if_drop;
    w_bus_err_next   = r_bus_err;

    // Results are consumed when the pipeline advances; a new completion below overrides.
    if (w_stall_n) begin
      w_if_done_next  = 1'b0;
      w_mem_done_next = 1'b0;
    end
    if (io_arb.ifKill) begin
      w_if_done_next = 1'b0;
    end

    unique case (r_state)
      StIdle: begin
        w_if_drop_next = 1'b0;
        if (io_arb.memReq && !r_mem_done) begin
          w_bus_req_next   = 1'b1;
          w_bus_we_next    = io_arb.memWe;
          w_bus_be_next    = io_arb.memBe;
          w_bus_addr_next  = io_arb.memAddr;
          w_bus_wdata_next = io_arb.memWdata;
          w_state_next     = StReqD;
        end else if (io_arb.ifReq && !r_if_done && !io_arb.ifKill) begin
          w_bus_req_next   = 1'b1;
          w_bus_we_next    = 1'b0;
          w_bus_be_next    = '1;
          w_bus_addr_next  = io_arb.ifAddr;
          w_bus_wdata_next = '0;
          w_state_next     = StReqI;
        end
      end
      // A response while still requesting breaks the protocol and is ignored.
      StReqD: begin
        if (io_arb.busGnt) begin
          w_bus_req_next = 1'b0;
          w_state_next   = StWaitD;
        end
      end
      StReqI: begin
        if (io_arb.busGnt) begin
          w_bus_req_next = 1'b0;
          w_state_next   = StWaitI;
        end
      end
      StWaitD: begin
        if (io_arb.busRvalid) begin
          if (!r_bus_we) begin
            w_mem_rdata_next = io_arb.busRdata;
          end
          w_mem_done_next = 1'b1;
          w_state_next    = StIdle;
        end
      end
      StWaitI: begin
        if (io_arb.busRvalid) begin
          if (!(r_if_drop || io_arb.ifKill)) begin
            w_if_rdata_next = io_arb.busRdata;
            w_if_done_next  = 1'b1;
          end
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase

    // Watchdog abort; a response arriving in the same cycle still completes normally.
    if (w_timer_expired && !w_rsp_now) begin
      w_state_next   = StIdle;
      w_bus_req_next = 1'b0;
      w_bus_err_next = 1'b1;
      if (is_fetch_state(r_state)) begin
        if (!(r_if_drop || io_arb.ifKill)) begin
          w_if_rdata_next = '0;
          w_if_done_next  = 1'b1;
        end
      end else begin
        w_mem_rdata_next = '0;
        w_mem_done_next  = 1'b1;
      end
    end

    // A killed fetch still drains on the bus; remember to throw its response away.
    if (is_fetch_state(r_state) && io_arb.ifKill && (w_state_next != StIdle)) begin
      w_if_drop_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_be    <= '0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_if_rdata  <= '0;
      r_if_done   <= 1'b0;
      r_mem_rdata <= '0;
      r_mem_done  <= 1'b0;
      r_if_drop   <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_bus_req   <= w_bus_req_next;
      r_bus_we    <= w_bus_we_next;
      r_bus_be    <= w_bus_be_next;
      r_bus_addr  <= w_bus_addr_next;
      r_bus_wdata <= w_bus_wdata_next;
      r_if_rdata  <= w_if_rdata_next;
      r_if_done   <= w_if_done_next;
      r_mem_rdata <= w_mem_rdata_next;
      r_mem_done  <= w_mem_done_next;
      r_if_drop   <= w_if_drop_next;
      r_bus_err   <= w_bus_err_next;
    end
  end

  assign io_arb.busReq   = r_bus_req;
  assign io_arb.busWe    = r_bus_we;
  assign io_arb.busBe    = r_bus_be;
  assign io_arb.busAddr  = r_bus_addr;
  assign io_arb.busWdata = r_bus_wdata;
  assign io_arb.ifRdata  = r_if_rdata;
  assign io_arb.ifDone   = r_if_done;
  assign io_arb.memRdata = r_mem_rdata;
  assign io_arb.memDone  = r_mem_done;
  assign io_arb.busErr   = r_bus_err;
  assign io_arb.stall_n  = w_stall_n;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (TIMEOUT_CYCLES = 8).
// Inputs are driven 1 time unit after the rising edge; registered outputs are read there too.
module tb_mem_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) arb ();

  mem_arbiter #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_arb(arb)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    arb.ifReq = 1'b0;  arb.ifAddr = '0;  arb.ifKill = 1'b0;
    arb.memReq = 1'b0; arb.memWe = 1'b0; arb.memBe = '0; arb.memAddr = '0; arb.memWdata = '0;
    arb.busGnt = 1'b0; arb.busRvalid = 1'b0; arb.busRdata = '0;
  endtask

  task automatic test_reset();
    logic [169:0] outs;
    clear_inputs();
    #1 rst_n = 1'b0;
    #2;
    outs = {arb.busReq, arb.busWe, arb.busBe, arb.busAddr, arb.busWdata, arb.ifRdata,
            arb.ifDone, arb.memRdata, arb.memDone, arb.busErr};
    n_checks++;
    if (outs !== '0) begin n_fail++; $display("FAIL reset_outputs got=%h exp=0", outs); end
    n_checks++;
    if (arb.stall_n !== 1'b1) begin n_fail++; $display("FAIL reset_stall got=%b exp=1", arb.stall_n); end
    tick();
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({arb.stall_n, arb.busReq} !== 2'b10) begin
        n_fail++; $display("FAIL idle_stall_busreq got=%b exp=10", {arb.stall_n, arb.busReq});
      end
    end
  endtask

  task automatic test_fetch();
    arb.ifReq = 1'b1; arb.ifAddr = 32'h100; #1;
    n_checks++;
    if (arb.stall_n !== 1'b0) begin n_fail++; $display("FAIL fetch_stall_req got=%b exp=0", arb.stall_n); end
    tick();
    n_checks++;
    if ({arb.busReq, arb.busWe, arb.busBe, arb.busAddr} !== {1'b1, 1'b0, 4'hF, 32'h100}) begin
      n_fail++; $display("FAIL fetch_bus got=%b%b%h_%h exp=10f_00000100",
                         arb.busReq, arb.busWe, arb.busBe, arb.busAddr);
    end
    arb.busGnt = 1'b1;
    tick();
    arb.busGnt = 1'b0;
    n_checks++;
    if ({arb.busReq, arb.ifDone} !== 2'b00) begin
      n_fail++; $display("FAIL fetch_wait got=%b exp=00", {arb.busReq, arb.ifDone});
    end
    tick();
    arb.busRvalid = 1'b1; arb.busRdata = 32'h00500093; #1;
    n_checks++;
    if (arb.stall_n !== 1'b0) begin n_fail++; $display("FAIL fetch_stall_rsp got=%b exp=0", arb.stall_n); end
    tick();
    arb.busRvalid = 1'b0;
    n_checks++;
    if ({arb.ifDone, arb.stall_n, arb.ifRdata} !== {2'b11, 32'h00500093}) begin
      n_fail++; $display("FAIL fetch_done got=%b%b_%h exp=11_00500093",
                         arb.ifDone, arb.stall_n, arb.ifRdata);
    end
    arb.ifReq = 1'b0;
    tick();
    n_checks++;
    if (arb.ifDone !== 1'b0) begin n_fail++; $display("FAIL fetch_done_clear got=%b exp=0", arb.ifDone); end
  endtask

  task automatic test_simultaneous();
    arb.memReq = 1'b1; arb.memWe = 1'b0; arb.memBe = 4'hF; arb.memAddr = 32'h2000;
    arb.ifReq = 1'b1; arb.ifAddr = 32'h104;
    tick();
    n_checks++;
    if ({arb.busReq, arb.busWe, arb.busAddr} !== {2'b10, 32'h2000}) begin
      n_fail++; $display("FAIL simul_first got=%b%b_%h exp=10_00002000",
                         arb.busReq, arb.busWe, arb.busAddr);
    end
    arb.busGnt = 1'b1;
    tick();
    arb.busGnt = 1'b0; arb.busRvalid = 1'b1; arb.busRdata = 32'hCAFEF00D;
    tick();
    arb.busRvalid = 1'b0; #1;
    n_checks++;
    if ({arb.memDone, arb.ifDone, arb.stall_n, arb.busReq, arb.memRdata} !== {4'b1000, 32'hCAFEF00D})
    begin
      n_fail++; $display("FAIL simul_mem_done got=%b%b%b%b_%h exp=1000_cafef00d",
                         arb.memDone, arb.ifDone, arb.stall_n, arb.busReq, arb.memRdata);
    end
    tick();
    n_checks++;
    if ({arb.busReq, arb.busAddr, arb.memDone} !== {1'b1, 32'h104, 1'b1}) begin
      n_fail++; $display("FAIL simul_second got=%b_%h_%b exp=1_00000104_1",
                         arb.busReq, arb.busAddr, arb.memDone);
    end
    arb.busGnt = 1'b1;
    tick();
    arb.busGnt = 1'b0; arb.busRvalid = 1'b1; arb.busRdata = 32'h00A00113; #1;
    n_checks++;
    if (arb.stall_n !== 1'b0) begin n_fail++; $display("FAIL simul_stall_mid got=%b exp=0", arb.stall_n); end
    tick();
    arb.busRvalid = 1'b0; #1;
    n_checks++;
    if ({arb.memDone, arb.ifDone, arb.stall_n, arb.ifRdata} !== {3'b111, 32'h00A00113}) begin
      n_fail++; $display("FAIL simul_both_done got=%b%b%b_%h exp=111_00a00113",
                         arb.memDone, arb.ifDone, arb.stall_n, arb.ifRdata);
    end
    arb.memReq = 1'b0; arb.ifReq = 1'b0;
    tick();
    n_checks++;
    if ({arb.memDone, arb.ifDone} !== 2'b00) begin
      n_fail++; $display("FAIL simul_clear got=%b exp=00", {arb.memDone, arb.ifDone});
    end
  endtask

  task automatic test_store();
    arb.memReq = 1'b1; arb.memWe = 1'b1; arb.memBe = 4'b0011; arb.memAddr = 32'h3000;
    arb.memWdata = 32'hDEADBEEF;
    tick();
    n_checks++;
    if ({arb.busReq, arb.busWe, arb.busBe, arb.busAddr, arb.busWdata} !==
        {2'b11, 4'b0011, 32'h3000, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL store_bus got=%b%b%b_%h_%h exp=110011_00003000_deadbeef",
                         arb.busReq, arb.busWe, arb.busBe, arb.busAddr, arb.busWdata);
    end
    arb.busGnt = 1'b1;
    tick();
    arb.busGnt = 1'b0; arb.busRvalid = 1'b1; arb.busRdata = 32'h55555555;
    tick();
    arb.busRvalid = 1'b0;
    n_checks++;
    if ({arb.memDone, arb.stall_n, arb.memRdata} !== {2'b11, 32'hCAFEF00D}) begin
      n_fail++; $display("FAIL store_done got=%b%b_%h exp=11_cafef00d",
                         arb.memDone, arb.stall_n, arb.memRdata);
    end
    arb.memReq = 1'b0; arb.memWe = 1'b0;
    tick();
    n_checks++;
    if (arb.memDone !== 1'b0) begin n_fail++; $display("FAIL store_clear got=%b exp=0", arb.memDone); end
  endtask

  task automatic test_kill();
    arb.ifReq = 1'b1; arb.ifAddr = 32'h200;
    tick();
    arb.busGnt = 1'b1;
    tick();
    arb.busGnt = 1'b0; arb.ifKill = 1'b1;
    tick();
    arb.ifKill = 1'b0; arb.ifAddr = 32'h300;
    arb.busRvalid = 1'b1; arb.busRdata = 32'h12345678;
    n_checks++;
    if (arb.busReq !== 1'b0) begin n_fail++; $display("FAIL kill_no_issue got=%b exp=0", arb.busReq); end
    tick();
    arb.busRvalid = 1'b0;
    n_checks++;
    if ({arb.ifDone, arb.busReq, arb.ifRdata} !== {2'b00, 32'h00A00113}) begin
      n_fail++; $display("FAIL kill_discard got=%b%b_%h exp=00_00a00113",
                         arb.ifDone, arb.busReq, arb.ifRdata);
    end
    tick();
    n_checks++;
    if ({arb.busReq, arb.busAddr} !== {1'b1, 32'h300}) begin
      n_fail++; $display("FAIL kill_refetch got=%b_%h exp=1_00000300", arb.busReq, arb.busAddr);
    end
    arb.busGnt = 1'b1;
    tick();
    arb.busGnt = 1'b0; arb.busRvalid = 1'b1; arb.busRdata = 32'h00000013;
    tick();
    arb.busRvalid = 1'b0;
    n_checks++;
    if ({arb.ifDone, arb.ifRdata} !== {1'b1, 32'h13}) begin
      n_fail++; $display("FAIL kill_refetch_done got=%b_%h exp=1_00000013", arb.ifDone, arb.ifRdata);
    end
    arb.ifReq = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    arb.memReq = 1'b1; arb.memWe = 1'b0; arb.memBe = 4'hF; arb.memAddr = 32'h4000;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 8) begin
        n_checks++;
        if ({arb.busReq, arb.busErr, arb.memDone} !== 3'b100) begin
          n_fail++; $display("FAIL timeout_last_cycle got=%b exp=100",
                             {arb.busReq, arb.busErr, arb.memDone});
        end
      end
    end
    tick();
    n_checks++;
    if ({arb.busErr, arb.memDone, arb.busReq, arb.memRdata} !== {3'b110, 32'h0}) begin
      n_fail++; $display("FAIL timeout_abort got=%b%b%b_%h exp=110_00000000",
                         arb.busErr, arb.memDone, arb.busReq, arb.memRdata);
    end
    arb.memReq = 1'b0;
    tick();
    n_checks++;
    if ({arb.busErr, arb.memDone} !== 2'b10) begin
      n_fail++; $display("FAIL timeout_sticky got=%b exp=10", {arb.busErr, arb.memDone});
    end
  endtask

  task automatic test_reset_mid_op();
    logic [169:0] outs;
    arb.memReq = 1'b1; arb.memWe = 1'b0; arb.memBe = 4'hF; arb.memAddr = 32'h5000;
    tick();
    arb.busGnt = 1'b1;
    tick();
    arb.busGnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    outs = {arb.busReq, arb.busWe, arb.busBe, arb.busAddr, arb.busWdata, arb.ifRdata,
            arb.ifDone, arb.memRdata, arb.memDone, arb.busErr};
    n_checks++;
    if (outs !== '0) begin n_fail++; $display("FAIL midreset_outputs got=%h exp=0", outs); end
    arb.memReq = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    arb.busRvalid = 1'b1; arb.busRdata = 32'hBAD0BAD0;
    tick();
    arb.busRvalid = 1'b0;
    n_checks++;
    if ({arb.memDone, arb.busReq, arb.stall_n, arb.memRdata} !== {3'b001, 32'h0}) begin
      n_fail++; $display("FAIL midreset_late_rvalid got=%b%b%b_%h exp=001_00000000",
                         arb.memDone, arb.busReq, arb.stall_n, arb.memRdata);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_fetch();
    test_simultaneous();
    test_store();
    test_kill();
    test_timeout();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
